// File: rtl/fifo_pkg.sv
// Shared definitions for the width-converting FIFO family: ratio constant,
// flag bundle type and elaboration-time helper functions.
package fifo_pkg;

  // Number of read words carried by one write word in the 4-in / 2-out FIFO.
  localparam int RATIO_W4R2 = 2;

  // Status flags presented to the consumer/producer.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Ceiling log2, used to size address buses from a depth.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Compare value for the almost flags, expressed in read words.
  // AlmostFull compares against the fill level leaving `amflag` free write
  // words; AlmostEmpty compares directly against `amflag` read words.
  function automatic int flag_threshold(input int numwordsw,
                                        input int amflag,
                                        input bit for_almost_full);
    int result;
    if (for_almost_full) begin
      result = RATIO_W4R2 * (numwordsw - amflag);
    end else begin
      result = amflag;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_w4r2.sv
// Storage array for the 4-in / 2-out FIFO: synchronous write, asynchronous
// read. Half-word selection and the output register live in the top level.
module fifo_ram_w4r2
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Word storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_scx_w4r2.sv
// Single-clock FIFO that accepts 4-bit words and returns them as two 2-bit
// words, low half first. Occupancy is tracked in read words so the flags can
// express the half-word left over after an odd number of reads.
module fifo_scx_w4r2
  import fifo_pkg::*;
#(
  parameter int module_widthw       = 4,
  parameter int module_widthr       = 2,
  parameter int module_widthuw      = 4,
  parameter int module_numwordsw    = 16,
  parameter int module_numwordsr    = 32,
  parameter int module_amfull_flag  = 1,
  parameter int module_amempty_flag = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [module_widthw-1:0] Data,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic                     RPReset,
  output logic [module_widthr-1:0] Q,
  output logic                     Full,
  output logic                     Empty,
  output logic                     AlmostFull,
  output logic                     AlmostEmpty
);

  localparam int AW    = module_widthuw;
  localparam int WP_W  = module_widthuw + 1;
  localparam int RP_W  = module_widthuw + 2;
  localparam int CNT_W = module_widthuw + 2;

  // Full once fewer than two read-word slots remain (no room for a write word).
  localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(module_numwordsr - 2);
  localparam logic [CNT_W-1:0] AF_TH   =
    CNT_W'(flag_threshold(module_numwordsw, module_amfull_flag, 1'b1));
  localparam logic [CNT_W-1:0] AE_TH   =
    CNT_W'(flag_threshold(module_numwordsw, module_amempty_flag, 1'b0));

  logic [WP_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [RP_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [module_widthr-1:0] q_q, q_d;

  fifo_flags_t              flags_s;
  logic                     wr_acc_s;
  logic                     rd_acc_s;
  logic [CNT_W-1:0]         wr_inc_s;
  logic [CNT_W-1:0]         rd_dec_s;
  logic [CNT_W-1:0]         replay_cnt_s;
  logic [module_widthw-1:0] rd_word_s;
  logic [module_widthr-1:0] rd_half_s;
  logic                     unused_s;

  // Pointer wrap bits are kept for the documented pointer widths but never
  // needed for addressing.
  assign unused_s = wr_ptr_q[WP_W-1] ^ rd_ptr_q[RP_W-1];

  fifo_ram_w4r2 #(
    .DEPTH (module_numwordsw),
    .WIDTH (module_widthw),
    .AW    (AW)
  ) u_ram (
    .clk   (Clock),
    .we    (wr_acc_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (Data),
    .raddr (rd_ptr_q[RP_W-2:1]),
    .rdata (rd_word_s)
  );

  // Status flags decoded from the registered occupancy.
  always_comb begin
    flags_s              = '0;
    flags_s.empty        = (cnt_q == '0);
    flags_s.full         = (cnt_q > FULL_TH);
    flags_s.almost_empty = (cnt_q <= AE_TH);
    flags_s.almost_full  = (cnt_q >= AF_TH);
  end

  assign Full        = flags_s.full;
  assign Empty       = flags_s.empty;
  assign AlmostFull  = flags_s.almost_full;
  assign AlmostEmpty = flags_s.almost_empty;
  assign Q           = q_q;

  // Acceptance of write and read requests; a pointer reset pre-empts reads.
  always_comb begin
    wr_acc_s = WrEn & ~flags_s.full;
    rd_acc_s = RdEn & ~flags_s.empty & ~RPReset;
    wr_inc_s = CNT_W'({wr_acc_s, 1'b0});
    rd_dec_s = CNT_W'(rd_acc_s);
    // After a pointer reset the FIFO holds everything from address 0 up to
    // the write position, including a write accepted on the same edge.
    replay_cnt_s = CNT_W'({wr_ptr_q[AW-1:0], 1'b0}) + wr_inc_s;
  end

  // Half-word select from the addressed storage word: low lane first.
  always_comb begin
    case (rd_ptr_q[0])
      1'b0:    rd_half_s = rd_word_s[module_widthr-1:0];
      1'b1:    rd_half_s = rd_word_s[module_widthw-1:module_widthr];
      default: rd_half_s = '0;
    endcase
  end

  // Next-state for pointers, occupancy and the output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    q_d      = q_q;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + WP_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (RPReset) begin
      rd_ptr_d = '0;
      cnt_d    = replay_cnt_s;
    end else begin
      cnt_d = cnt_q + wr_inc_s - rd_dec_s;
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + RP_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end

    if (rd_acc_s) begin
      q_d = rd_half_s;
    end else begin
      q_d = q_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
    end
  end

endmodule
